// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic constants, carry tokens and FSM state type
// Purpose: token encodings for the ASCII carry convention, default datapath
//          widths and the state enum used by the digit-serial subtractor.
// Ports:   none (package).
package arith_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 8;

  // ASCII carry tokens: kill (no borrow), generate (borrow), propagate (reserved)
  localparam logic [7:0] TOK_K = 8'h6B;
  localparam logic [7:0] TOK_G = 8'h67;
  localparam logic [7:0] TOK_P = 8'h70;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtraction is a + ~b + c, so a borrow-in of 1 means an adder carry-in of 0.
  // Only "g" borrows; "k", the reserved "p" and anything else borrow nothing.
  function automatic logic tok_to_carry(input logic [7:0] tok);
    return (tok != TOK_G);
  endfunction

endpackage

// File: rtl/rdsub_serial_if.sv
// rtl/rdsub_serial_if.sv - start/done operand/result bundle for rdsub_serial
// Purpose: groups the sequencer-facing handshake and data signals.
// Ports:   start, a, b, xin   (sequencer -> subtractor)
//          busy, done, d, xout, ovf (subtractor -> sequencer)
// Modports: master = controlling sequencer, slave = subtractor.
interface rdsub_serial_if #(
  parameter int WIDTH = arith_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [7:0]       xin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic [7:0]       xout;
  logic             ovf;

  modport master (
    output start, a, b, xin,
    input  busy, done, d, xout, ovf
  );

  modport slave (
    input  start, a, b, xin,
    output busy, done, d, xout, ovf
  );

endinterface

// File: rtl/rdsub_digit.sv
// rtl/rdsub_digit.sv - combinational DIGIT-bit subtract slice
// Purpose: computes i_a_d + ~i_b_d + i_cin as a ripple of full adders.
// Ports:   i_a_d    DIGIT  minuend digit
//          i_b_d    DIGIT  subtrahend digit
//          i_cin    1      adder carry-in (1 = no borrow)
//          o_diff_d DIGIT  difference digit
//          o_cout   1      adder carry-out (1 = no borrow)
module rdsub_digit #(
  parameter int DIGIT = arith_pkg::DIGIT_DEF
) (
  input  logic [DIGIT-1:0] i_a_d,
  input  logic [DIGIT-1:0] i_b_d,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_diff_d,
  output logic             o_cout
);

  logic [DIGIT-1:0] w_b_n;
  logic [DIGIT:0]   w_c;

  assign w_b_n  = ~i_b_d;
  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign o_diff_d[gi] = i_a_d[gi] ^ w_b_n[gi] ^ w_c[gi];
    assign w_c[gi+1]    = (i_a_d[gi] & w_b_n[gi]) | (w_c[gi] & (i_a_d[gi] ^ w_b_n[gi]));
  end

  assign o_cout = w_c[DIGIT];

endmodule

// File: rtl/rdsub_serial.sv
// rtl/rdsub_serial.sv - digit-serial two's-complement subtractor, d = a - b - borrow_in
// Purpose: processes DIGIT bits per clock over WIDTH/DIGIT cycles with a
//          start/done handshake; WIDTH must be a multiple of DIGIT, with at
//          least two digits.
// Ports:   clk    rising-edge clock
//          reset  asynchronous active-high reset
//          bus    rdsub_serial_if.slave (start, a, b, xin in; busy, done, d, xout, ovf out)
module rdsub_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  rdsub_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic [7:0]       r_xout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_diff;
  logic             w_cout;
  logic [WIDTH-1:0] w_full;

  assign w_a_dig = r_a[r_count*DIGIT +: DIGIT];
  assign w_b_dig = r_b[r_count*DIGIT +: DIGIT];

  rdsub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a_d    (w_a_dig),
    .i_b_d    (w_b_dig),
    .i_cin    (r_c),
    .o_diff_d (w_diff),
    .o_cout   (w_cout)
  );

  // New digits enter at the top and slide down; after NDIG shifts digit 0
  // sits in the low slice. On the last digit w_full is the complete result.
  assign w_full = {w_diff, r_res[WIDTH-1:DIGIT]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_xout  <= TOK_K;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_c     <= tok_to_carry(bus.xin);
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_res   <= w_full;
          r_c     <= w_cout;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_d     <= w_full;
            // Final adder carry of 1 means no borrow out of the top digit.
            r_xout  <= w_cout ? TOK_K : TOK_G;
            // Overflow only possible when operand signs differ.
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_full[WIDTH-1] != r_a[WIDTH-1]);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.d    = r_d;
  assign bus.xout = r_xout;
  assign bus.ovf  = r_ovf;

endmodule

// File: doc/rdsub_serial.md
Name: rdsub_serial

Overview:
- Digit-serial 32-bit two's-complement subtractor that computes d = a - b - borrow_in, 8 bits per clock over 4 cycles.
- It is the inverse-operation counterpart of the combinational ripple adder.
- It uses the same ASCII carry-token convention on xin/xout: "k" means kill (no borrow) and "g" means generate (borrow).
- It sits in the arithmetic datapath where area matters more than latency, with a start/done handshake toward the controlling sequencer.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per clock; NDIG = WIDTH/DIGIT = 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  32  signed minuend; sampled on the accepting edge
- b  input  32  signed subtrahend; sampled on the accepting edge
- xin  input  8  borrow-in token: "g" (8'h67) means borrow 1; any other value means borrow 0 ("k" is the canonical value)
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse; d, xout and ovf are valid from this cycle
- d  output  32  signed difference, held until the next completion
- xout  output  8  borrow-out token: "g" if unsigned a < b + borrow_in, else "k" (8'h6B)
- ovf  output  1  signed overflow of a - b - borrow_in

Behaviour:
- Reset (async, any state): state=IDLE, count=0, busy=0, done=0, d=0, xout="k", ovf=0. Operand registers are cleared to 0. Any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge N:
  - Latch a, b, and carry register c = !(xin=="g").
  - Set count=0, go to RUN, busy=1.
  - done falls at this edge if it was set.
- IDLE/DONE with start=0:
  - DONE returns to IDLE next edge; done=0.
  - d, xout and ovf hold.
- RUN, each edge:
  - Digit k=count: sum = a[k] + ~b[k] + c, computed DIGIT+1 bits wide.
  - Write the low DIGIT bits into a result shift register at slice k.
  - c = sum[DIGIT]; count = count+1.
- Edge N+4 (last digit):
  - Go to DONE. Publish d from the full result.
  - xout = "k" if the final carry c=1, else "g".
  - ovf = (a[31] != b[31]) && (d[31] != a[31]).
  - busy=0, done=1.
- Latency: done is high in the cycle following edge N+4, exactly 4 cycles after the accepting edge. Throughput is one operation per 5 cycles; back-to-back is allowed, and start in DONE is accepted at edge N+5.
- start while in RUN is ignored (no queuing) and the operands are not re-sampled.
- d, xout and ovf change only at the completion edge and at reset. Intermediate digits are never visible on d.
- Wrap-around: results are modulo 2^32. 0x80000000-1 gives 0x7FFFFFFF with ovf=1.
- xin is sampled only on the accepting edge.

Decomposition:
- Shared package arith_pkg:
  - Token constants TOK_K=8'h6B, TOK_G=8'h67, TOK_P=8'h70 (P is reserved, and is treated as borrow 0 on xin).
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH/DIGIT constants.
- One natural sub-module: rdsub_digit, a combinational DIGIT-bit subtract slice taking (a_d, b_d, cin) and producing (diff_d, cout), internally a ripple of full adders on ~b. The top module holds the FSM, counter, operand and result registers.

Test Plan:
- a=36865, b=33023, xin="k", start pulse → done 4 cycles later. Expect d=3842, xout="k", ovf=0; busy high for exactly 4 cycles.
- a=1, b=-2, xin="k" → d=3, xout="g" (unsigned 1 < 0xFFFFFFFE), ovf=0. Then a=1, b=2 → d=-1 (0xFFFFFFFF), xout="g".
- a=5, b=3, xin="g" → d=1, xout="k". Also a=0x80000000, b=1, xin="k" → d=0x7FFFFFFF, ovf=1, xout="k".
- Start a=100, b=40. Pulse start again with a=7, b=7 two cycles later → ignored; d=60 at the expected cycle. Start in the DONE cycle → accepted, second result arrives 5 cycles after the first.
- Assert reset during RUN after 2 digits → immediately busy=0, done=0, d=0, xout="k". No done pulse follows. A fresh start after release completes normally.
